spi_slave_responder: RTL and testbench

SPI mode-0 slave that answers the AXI-Lite SPI master wrapper from the other end of the link. It oversamples SCLK/SS/MOSI in its own clock domain, deserialises MOSI into bytes, and serialises a host-loaded response byte onto MISO during the same frame. It sits in peripheral models and loopback-free benches as the device the SPI master talks to, and is synthesisable for FPGA slave endpoints.

---
 rtl/spi_slave_responder.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave endpoint: oversamples SCLK/SS/MOSI in the ACLK domain, deserialises
// MOSI words and shifts a host-loaded (or default) response word out on MISO.
module spi_slave_responder #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = DATA_WIDTH'(8'hFF)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                state_reg;
  logic [2:0]            sclk_sync_reg;
  logic [2:0]            ss_sync_reg;
  logic [1:0]            mosi_sync_reg;
  logic [1:0]            settle_reg;
  logic                  armed_reg;
  logic                  full_reg;
  logic [DATA_WIDTH-1:0] buffer_reg;
  logic [DATA_WIDTH-1:0] shift_tx_reg;
  logic [DATA_WIDTH-1:0] shift_rx_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic                  underrun_pend_reg;
  logic                  miso_reg;
  logic                  miso_oe_reg;
  logic [DATA_WIDTH-1:0] rx_data_reg;
  logic                  rx_valid_reg;
  logic                  tx_underrun_reg;
  logic                  frame_err_reg;

  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_high;
  logic tx_load;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  assign ss_high   = ss_sync_reg[1];
  // A frame already in progress when reset released must not look like a fresh select.
  assign ss_fall   = armed_reg & ~ss_sync_reg[1] & ss_sync_reg[2];
  assign tx_load   = tx_valid & ~full_reg;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sclk_sync_reg <= '0;
      ss_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      settle_reg    <= '0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], SCLK};
      ss_sync_reg   <= {ss_sync_reg[1:0], SS};
      mosi_sync_reg <= {mosi_sync_reg[0], MOSI};
      if (settle_reg != 2'd2) settle_reg <= settle_reg + 2'd1;
      if (settle_reg == 2'd2 && ss_sync_reg[1]) armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg         <= IDLE;
      full_reg          <= 1'b0;
      buffer_reg        <= '0;
      shift_tx_reg      <= '0;
      shift_rx_reg      <= '0;
      bit_cnt_reg       <= '0;
      underrun_pend_reg <= 1'b0;
      miso_reg          <= 1'b0;
      miso_oe_reg       <= 1'b0;
      rx_data_reg       <= '0;
      rx_valid_reg      <= 1'b0;
      tx_underrun_reg   <= 1'b0;
      frame_err_reg     <= 1'b0;
    end else begin
      rx_valid_reg    <= 1'b0;
      tx_underrun_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      miso_oe_reg     <= ~ss_high;

      if (tx_load) begin
        buffer_reg <= tx_data;
        full_reg   <= 1'b1;
      end else if (state_reg == LOAD) begin
        full_reg   <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          miso_reg          <= 1'b0;
          bit_cnt_reg       <= '0;
          underrun_pend_reg <= 1'b0;
          if (ss_fall) state_reg <= LOAD;
        end
        LOAD: begin
          if (full_reg) begin
            shift_tx_reg <= buffer_reg;
            miso_reg     <= buffer_reg[DATA_WIDTH-1];
          end else begin
            shift_tx_reg <= DEFAULT_TX;
            miso_reg     <= DEFAULT_TX[DATA_WIDTH-1];
          end
          underrun_pend_reg <= ~full_reg;
          bit_cnt_reg       <= '0;
          state_reg         <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt_reg == CW'(DATA_WIDTH)) begin
            rx_data_reg  <= shift_rx_reg;
            rx_valid_reg <= 1'b1;
            state_reg    <= ss_high ? IDLE : LOAD;
          end else if (ss_high) begin
            frame_err_reg <= (bit_cnt_reg != '0);
            state_reg     <= IDLE;
          end else begin
            // Underrun is reported once the master clocks the word, so the trailing
            // LOAD that follows a frame's final word stays silent.
            if (sclk_rise) begin
              shift_rx_reg <= {shift_rx_reg[DATA_WIDTH-2:0], mosi_sync_reg[1]};
              bit_cnt_reg  <= bit_cnt_reg + CW'(1);
              if (bit_cnt_reg == '0 && underrun_pend_reg) begin
                tx_underrun_reg   <= 1'b1;
                underrun_pend_reg <= 1'b0;
              end
            end
            // The previous word's final fall arrives after the next LOAD; bit_cnt=0 skips it.
            if (sclk_fall && bit_cnt_reg != '0) begin
              shift_tx_reg <= {shift_tx_reg[DATA_WIDTH-2:0], 1'b0};
              miso_reg     <= shift_tx_reg[DATA_WIDTH-2];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign MISO        = miso_reg;
  assign MISO_OE     = miso_oe_reg;
  assign tx_ready    = ~full_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_underrun = tx_underrun_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a bit-level SPI mode-0 master (SCLK = ACLK/8) plus a
// word-level expectation model (MOSI words in, loaded words or 0xFF out).
module tb_spi_slave_responder;

  localparam int DW = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          SCLK = 1'b0;
  logic          SS = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic          MISO_OE;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_underrun;
  logic          frame_err;

  spi_slave_responder #(.DATA_WIDTH(DW), .DEFAULT_TX(8'hFF)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  // Pulse monitors
  int            rxv_cnt = 0;
  int            und_cnt = 0;
  int            ferr_cnt = 0;
  logic [DW-1:0] rx_q[$];

  always @(negedge ACLK) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_underrun) und_cnt++;
    if (frame_err) ferr_cnt++;
  end

  // Per-frame stimulus and captured MISO words
  logic [DW-1:0] mosi_w[4];
  logic [DW-1:0] miso_w[4];
  logic [DW-1:0] tx_w[4];
  bit            have_tx[4];
  int            bits_done = 0;
  logic [DW-1:0] last_rx = '0;
  int            r0, u0, f0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic snap();
    r0 = rxv_cnt; u0 = und_cnt; f0 = ferr_cnt;
    rx_q.delete();
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    int t = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 200) begin
      wait_cyc(1);
      t++;
    end
    if (t >= 200) begin
      checks++; failures++;
      $display("FAIL send_tx_timeout tx_ready=%b required=1", tx_ready);
    end
    wait_cyc(1);
    tx_valid = 1'b0;
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled at the rising edge.
  task automatic master(input int nwords, input int abort_at);
    bit stop = 0;
    SS = 1'b0;
    wait_cyc(8);
    for (int w = 0; w < nwords; w++) begin
      for (int i = 0; i < DW; i++) begin
        if (abort_at >= 0 && w * DW + i == abort_at) stop = 1;
        if (!stop) begin
          MOSI = mosi_w[w][DW-1-i];
          wait_cyc(4);
          miso_w[w][DW-1-i] = MISO;
          SCLK = 1'b1;
          bits_done++;
          wait_cyc(4);
          SCLK = 1'b0;
        end
      end
    end
    wait_cyc(4);
    SS = 1'b1;
    MOSI = 1'b0;
    wait_cyc(8);
  endtask

  task automatic run_frame(input int nwords, input int abort_at);
    bits_done = 0;
    if (have_tx[0]) send_tx(tx_w[0]);
    fork
      master(nwords, abort_at);
      begin
        for (int w = 1; w < nwords; w++) begin
          if (have_tx[w]) begin
            int t = 0;
            while (bits_done < (w - 1) * DW + 1 && t < 500) begin
              wait_cyc(1);
              t++;
            end
            if (t >= 500) begin
              checks++; failures++;
              $display("FAIL loader_timeout bits_done=%0d required>=%0d", bits_done, (w - 1) * DW + 1);
            end
            send_tx(tx_w[w]);
          end
        end
      end
    join
    for (int w = 0; w < nwords; w++)
      $display("word %0d: mosi=%h miso=%h rx_valid_total=%0d", w, mosi_w[w], miso_w[w], rxv_cnt);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    wait_cyc(3);
    checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", MISO); end
    checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", MISO_OE); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    ARESET = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_basic();
    snap();
    send_tx(8'h3C);
    checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_full got=%b exp=0", tx_ready); end
    mosi_w[0] = 8'hA5; have_tx[0] = 0;
    run_frame(1, -1);
    checks++; if (rxv_cnt - r0 != 1) begin failures++; $display("FAIL basic_rxv_count got=%0d exp=1", rxv_cnt - r0); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_rx_data got=%h exp=a5", rx_data); end
    checks++; if (miso_w[0] !== 8'h3C) begin failures++; $display("FAIL basic_miso got=%h exp=3c", miso_w[0]); end
    checks++; if (und_cnt - u0 != 0) begin failures++; $display("FAIL basic_underrun got=%0d exp=0", und_cnt - u0); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", tx_ready); end
    last_rx = 8'hA5;
  endtask

  task automatic test_underrun();
    snap();
    mosi_w[0] = 8'h5A; have_tx[0] = 0;
    run_frame(1, -1);
    checks++; if (miso_w[0] !== 8'hFF) begin failures++; $display("FAIL underrun_miso got=%h exp=ff", miso_w[0]); end
    checks++; if (und_cnt - u0 != 1) begin failures++; $display("FAIL underrun_count got=%0d exp=1", und_cnt - u0); end
    checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL underrun_rx_data got=%h exp=5a", rx_data); end
    checks++; if (rxv_cnt - r0 != 1) begin failures++; $display("FAIL underrun_rxv got=%0d exp=1", rxv_cnt - r0); end
    last_rx = 8'h5A;
  endtask

  task automatic test_back_to_back();
    snap();
    mosi_w[0] = 8'($urandom); mosi_w[1] = 8'($urandom);
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; have_tx[0] = 1; have_tx[1] = 1;
    run_frame(2, -1);
    checks++; if (rxv_cnt - r0 != 2) begin failures++; $display("FAIL b2b_rxv got=%0d exp=2", rxv_cnt - r0); end
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (rx_q.size() <= w || rx_q[w] !== mosi_w[w]) begin
        failures++; $display("FAIL b2b_rx_word%0d got=%h exp=%h", w, (rx_q.size() > w) ? rx_q[w] : 8'hxx, mosi_w[w]);
      end
      checks++;
      if (miso_w[w] !== tx_w[w]) begin failures++; $display("FAIL b2b_miso_word%0d got=%h exp=%h", w, miso_w[w], tx_w[w]); end
    end
    checks++; if (und_cnt - u0 != 0) begin failures++; $display("FAIL b2b_underrun got=%0d exp=0", und_cnt - u0); end
    last_rx = mosi_w[1];
  endtask

  task automatic test_frame_err();
    snap();
    mosi_w[0] = 8'hC3; have_tx[0] = 0;
    run_frame(1, 3);
    checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (rxv_cnt - r0 != 0) begin failures++; $display("FAIL ferr_rxv got=%0d exp=0", rxv_cnt - r0); end
    checks++; if (rx_data !== last_rx) begin failures++; $display("FAIL ferr_rx_hold got=%h exp=%h", rx_data, last_rx); end
    snap();
    mosi_w[0] = 8'h81;
    run_frame(1, -1);
    checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL ferr_next_rx got=%h exp=81", rx_data); end
    checks++; if (ferr_cnt - f0 != 0) begin failures++; $display("FAIL ferr_next_clean got=%0d exp=0", ferr_cnt - f0); end
    last_rx = 8'h81;
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] t;
    mosi_w[0] = 8'h3F; have_tx[0] = 0;
    snap();
    fork
      master(1, -1);
      begin
        wait_cyc(8 + 3 * 8 + 2);
        ARESET = 1'b1;
        wait_cyc(1);
        checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL midrst_miso got=%b exp=0", MISO); end
        checks++; if (MISO_OE !== 1'b0) begin failures++; $display("FAIL midrst_oe got=%b exp=0", MISO_OE); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid got=%b exp=0", rx_valid); end
        ARESET = 1'b0;
      end
    join
    checks++; if (rxv_cnt - r0 != 0) begin failures++; $display("FAIL midrst_no_rxv got=%0d exp=0", rxv_cnt - r0); end
    checks++; if (ferr_cnt - f0 != 0) begin failures++; $display("FAIL midrst_no_ferr got=%0d exp=0", ferr_cnt - f0); end
    snap();
    t = 8'($urandom);
    mosi_w[0] = 8'h96; tx_w[0] = t; have_tx[0] = 1;
    run_frame(1, -1);
    checks++; if (rx_data !== 8'h96) begin failures++; $display("FAIL midrst_next_rx got=%h exp=96", rx_data); end
    checks++; if (miso_w[0] !== t) begin failures++; $display("FAIL midrst_next_miso got=%h exp=%h", miso_w[0], t); end
  endtask

  task automatic test_load_collision();
    logic [DW-1:0] x;
    x = 8'($urandom);
    mosi_w[0] = 8'($urandom); mosi_w[1] = 8'($urandom);
    snap();
    bits_done = 0;
    fork
      master(2, -1);
      begin
        // SS low at pins -> LOAD acts on the 4th edge; offer the word exactly there.
        wait_cyc(3);
        tx_data = x;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
      end
    join
    $display("collision: offered=%h miso0=%h miso1=%h", x, miso_w[0], miso_w[1]);
    checks++; if (miso_w[0] !== 8'hFF) begin failures++; $display("FAIL coll_word0 got=%h exp=ff", miso_w[0]); end
    checks++; if (miso_w[1] !== x) begin failures++; $display("FAIL coll_word1 got=%h exp=%h", miso_w[1], x); end
    checks++; if (und_cnt - u0 != 1) begin failures++; $display("FAIL coll_underrun got=%0d exp=1", und_cnt - u0); end
    checks++; if (rxv_cnt - r0 != 2) begin failures++; $display("FAIL coll_rxv got=%0d exp=2", rxv_cnt - r0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nw;
      int exp_und = 0;
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) begin
        mosi_w[w] = 8'($urandom);
        tx_w[w] = 8'($urandom);
        have_tx[w] = bit'($urandom_range(0, 1));
        if (!have_tx[w]) exp_und++;
      end
      snap();
      run_frame(nw, -1);
      checks++; if (rxv_cnt - r0 != nw) begin failures++; $display("FAIL rand%0d_rxv got=%0d exp=%0d", it, rxv_cnt - r0, nw); end
      checks++; if (und_cnt - u0 != exp_und) begin failures++; $display("FAIL rand%0d_underrun got=%0d exp=%0d", it, und_cnt - u0, exp_und); end
      for (int w = 0; w < nw; w++) begin
        logic [DW-1:0] exp_miso;
        exp_miso = have_tx[w] ? tx_w[w] : 8'hFF;
        checks++;
        if (rx_q.size() <= w || rx_q[w] !== mosi_w[w]) begin
          failures++; $display("FAIL rand%0d_rx_word%0d got=%h exp=%h", it, w, (rx_q.size() > w) ? rx_q[w] : 8'hxx, mosi_w[w]);
        end
        checks++;
        if (miso_w[w] !== exp_miso) begin failures++; $display("FAIL rand%0d_miso_word%0d got=%h exp=%h", it, w, miso_w[w], exp_miso); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_frame_err();
    test_reset_mid_frame();
    test_load_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
